// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: access-size encodings, LSU FSM states, data-memory region default
package load_store_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] DMEM_REGION_DEF = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Bytes never misalign; halves need addr[0]=0; words (and size 11) need addr[1:0]=0
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SIZE_BYTE) ? 1'b0 : (size == SIZE_HALF) ? addr_lo[0] : (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: byte-lane select, store data replication and load extraction/extension
module lsu_data_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_byte_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        is_byte;
    logic        is_half;

    // Lane selection on the store side and lane extraction plus extension on the load side
    always_comb begin
        is_byte    = (size_i == SIZE_BYTE);
        is_half    = (size_i == SIZE_HALF);
        byte_v     = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_v     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sel_byte_o = is_byte ? (4'b0001 << addr_lo_i) :
                     is_half ? (4'b0011 << {addr_lo_i[1], 1'b0}) : 4'b1111;
        wdata_o    = is_byte ? {4{wdata_i[7:0]}} :
                     is_half ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o    = is_byte ? {{24{byte_v[7] & ~unsigned_i}}, byte_v} :
                     is_half ? {{16{half_v[15] & ~unsigned_i}}, half_v} : rdata_i;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: execute-to-data-bus load/store sequencer; LSU_BUS_TIMEOUT_EN enables the WAIT-state bus timeout
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter logic [3:0] DMEM_REGION = DMEM_REGION_DEF
`ifdef LSU_BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exe2lsu_req_i,
    input  logic        exe2lsu_we_i,
    input  logic [1:0]  exe2lsu_size_i,
    input  logic        exe2lsu_unsigned_i,
    input  logic [31:0] exe2lsu_addr_i,
    input  logic [31:0] exe2lsu_wdata_i,
    output logic        lsu2exe_stall_o,
    output logic        lsu2dbus_req_o,
    output logic        lsu2dbus_we_o,
    output logic [31:0] lsu2dbus_addr_o,
    output logic [31:0] lsu2dbus_wdata_o,
    output logic [3:0]  lsu2dbus_sel_byte_o,
    output logic        lsu2dbus_dmem_sel_o,
    output logic        lsu2dbus_peri_sel_o,
    input  logic [31:0] dbus2lsu_rdata_i,
    input  logic        dbus2lsu_ack_i,
    output logic        lsu2wrb_valid_o,
    output logic [31:0] lsu2wrb_rdata_o,
    output logic        lsu2csr_misalign_o,
    output logic        lsu2csr_is_store_o,
    output logic [31:0] lsu2csr_badaddr_o,
    output logic        lsu2csr_bus_err_o
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        dmem_q, dmem_d;
    logic        misalign_q, misalign_d;
    logic        is_store_q, is_store_d;
    logic [31:0] badaddr_q, badaddr_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;

    logic        idle;
    logic        misaligned;
    logic        timeout;
    logic [1:0]  al_size;
    logic        al_uns;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

`ifdef LSU_BUS_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    assign timeout = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // In IDLE the aligner sees the incoming request; afterwards it formats the captured load
    assign idle       = (state_q == ST_IDLE);
    assign al_size    = idle ? exe2lsu_size_i : size_q;
    assign al_uns     = idle ? exe2lsu_unsigned_i : uns_q;
    assign al_addr_lo = idle ? exe2lsu_addr_i[1:0] : addr_q[1:0];
    assign misaligned = is_misaligned(exe2lsu_size_i, exe2lsu_addr_i[1:0]);

    lsu_data_align u_align (
        .size_i     (al_size),
        .unsigned_i (al_uns),
        .addr_lo_i  (al_addr_lo),
        .wdata_i    (exe2lsu_wdata_i),
        .rdata_i    (dbus2lsu_rdata_i),
        .sel_byte_o (al_sel),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata)
    );

    assign lsu2exe_stall_o     = (idle & exe2lsu_req_i & ~misaligned) |
                                 (state_q == ST_REQ) | (state_q == ST_WAIT);
    assign lsu2dbus_req_o      = (state_q == ST_REQ);
    assign lsu2dbus_we_o       = lsu2dbus_req_o & we_q;
    assign lsu2dbus_addr_o     = lsu2dbus_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
    assign lsu2dbus_wdata_o    = lsu2dbus_req_o ? wdata_q : 32'h0;
    assign lsu2dbus_sel_byte_o = lsu2dbus_req_o ? sel_q : 4'h0;
    assign lsu2dbus_dmem_sel_o = lsu2dbus_req_o & dmem_q;
    assign lsu2dbus_peri_sel_o = lsu2dbus_req_o & ~dmem_q;
    assign lsu2wrb_valid_o     = valid_q;
    assign lsu2wrb_rdata_o     = rdata_q;
    assign lsu2csr_misalign_o  = misalign_q;
    assign lsu2csr_is_store_o  = is_store_q;
    assign lsu2csr_badaddr_o   = badaddr_q;
    assign lsu2csr_bus_err_o   = bus_err_q;

    // Next-state and one-cycle status pulses for the IDLE/REQ/WAIT/RESP sequence
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        dmem_d     = dmem_q;
        misalign_d = 1'b0;
        is_store_d = 1'b0;
        badaddr_d  = 32'h0;
        valid_d    = 1'b0;
        rdata_d    = 32'h0;
        bus_err_d  = 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
        cnt_d      = (state_q == ST_WAIT) ? cnt_q + 8'd1 : 8'd0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (exe2lsu_req_i && misaligned) begin
                    misalign_d = 1'b1;
                    is_store_d = exe2lsu_we_i;
                    badaddr_d  = exe2lsu_addr_i;
                end else if (exe2lsu_req_i) begin
                    state_d = ST_REQ;
                    we_d    = exe2lsu_we_i;
                    size_d  = exe2lsu_size_i;
                    uns_d   = exe2lsu_unsigned_i;
                    addr_d  = exe2lsu_addr_i;
                    wdata_d = al_wdata;
                    sel_d   = al_sel;
                    dmem_d  = (exe2lsu_addr_i[31:28] == DMEM_REGION);
                end
            end
            ST_REQ: state_d = ST_WAIT;
            ST_WAIT: begin
                if (dbus2lsu_ack_i) begin
                    state_d = ST_RESP;
                    valid_d = 1'b1;
                    rdata_d = we_q ? 32'h0 : al_rdata;
                end else if (timeout) begin
                    state_d    = ST_RESP;
                    valid_d    = 1'b1;
                    bus_err_d  = 1'b1;
                    is_store_d = we_q;
                    badaddr_d  = addr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; synchronous active-low reset drops any in-flight access
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            sel_q      <= 4'h0;
            dmem_q     <= 1'b0;
            misalign_q <= 1'b0;
            is_store_q <= 1'b0;
            badaddr_q  <= 32'h0;
            valid_q    <= 1'b0;
            rdata_q    <= 32'h0;
            bus_err_q  <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
            cnt_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            dmem_q     <= dmem_d;
            misalign_q <= misalign_d;
            is_store_q <= is_store_d;
            badaddr_q  <= badaddr_d;
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
`ifdef LSU_BUS_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a programmable-latency bus slave
module tb_load_store_unit;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        dmem;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        st;
        logic [31:0] addr;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        st;
    } mis_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        stall;
    logic        dreq, dwe, dmem_sel, peri_sel;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dsel;
    logic [31:0] drdata;
    logic        dack;
    logic        wvalid;
    logic [31:0] wrdata;
    logic        misalign, is_store, bus_err;
    logic [31:0] badaddr;

    int checks = 0;
    int errors = 0;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    mis_t  mis_q[$];

    int          ack_wait = 0;
    logic [31:0] slave_rdata = 32'h0;
    bit          slave_busy = 1'b0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .exe2lsu_req_i       (req),
        .exe2lsu_we_i        (we),
        .exe2lsu_size_i      (size),
        .exe2lsu_unsigned_i  (uns),
        .exe2lsu_addr_i      (addr),
        .exe2lsu_wdata_i     (wdata),
        .lsu2exe_stall_o     (stall),
        .lsu2dbus_req_o      (dreq),
        .lsu2dbus_we_o       (dwe),
        .lsu2dbus_addr_o     (daddr),
        .lsu2dbus_wdata_o    (dwdata),
        .lsu2dbus_sel_byte_o (dsel),
        .lsu2dbus_dmem_sel_o (dmem_sel),
        .lsu2dbus_peri_sel_o (peri_sel),
        .dbus2lsu_rdata_i    (drdata),
        .dbus2lsu_ack_i      (dack),
        .lsu2wrb_valid_o     (wvalid),
        .lsu2wrb_rdata_o     (wrdata),
        .lsu2csr_misalign_o  (misalign),
        .lsu2csr_is_store_o  (is_store),
        .lsu2csr_badaddr_o   (badaddr),
        .lsu2csr_bus_err_o   (bus_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus slave: acks (ack_wait+1) cycles after seeing a request
    initial begin
        dack   = 1'b0;
        drdata = 32'h0;
        forever begin
            @(negedge clk);
            if (dreq) begin
                slave_busy = 1'b1;
                repeat (ack_wait + 1) @(negedge clk);
                dack   = 1'b1;
                drdata = slave_rdata;
                @(negedge clk);
                dack   = 1'b0;
                drdata = 32'h0;
                slave_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a bus request, response or trap
    bus_t  mb;
    resp_t mr;
    mis_t  mm;
    initial forever begin
        @(negedge clk);
        if (dreq) begin
            if (bus_q.size() == 0) check("bus_unexpected", 32'd1, 32'd0);
            else begin
                mb = bus_q.pop_front();
                check("bus_addr", daddr, mb.addr);
                check("bus_we", 32'(dwe), 32'(mb.we));
                check("bus_wdata", dwdata, mb.wdata);
                check("bus_sel", 32'(dsel), 32'(mb.sel));
                check("bus_dmem", 32'(dmem_sel), 32'(mb.dmem));
                check("bus_peri", 32'(peri_sel), 32'(!mb.dmem));
            end
        end
        if (wvalid) begin
            if (resp_q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
            else begin
                mr = resp_q.pop_front();
                check("wrb_rdata", wrdata, mr.rdata);
                check("bus_err", 32'(bus_err), 32'(mr.err));
                if (mr.err) begin
                    check("err_badaddr", badaddr, mr.addr);
                    check("err_is_store", 32'(is_store), 32'(mr.st));
                end
            end
        end
        if (misalign) begin
            if (mis_q.size() == 0) check("mis_unexpected", 32'd1, 32'd0);
            else begin
                mm = mis_q.pop_front();
                check("mis_badaddr", badaddr, mm.addr);
                check("mis_is_store", 32'(is_store), 32'(mm.st));
            end
        end
    end

    task automatic wait_slave();
        int n = 0;
        while (slave_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (slave_busy) check("slave_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic i_we, input logic [1:0] i_size, input logic i_uns,
                          input logic [31:0] i_addr, input logic [31:0] i_wd, input logic [31:0] i_rd,
                          input int wait_c, input int exp_lat, input logic [31:0] exp_rd,
                          input logic exp_err, input logic [3:0] exp_sel, input logic [31:0] exp_wd,
                          input logic exp_dmem);
        int cyc = 0;
        bit done = 1'b0;
        wait_slave();
        slave_rdata = i_rd;
        ack_wait    = wait_c;
        @(negedge clk);
        req = 1'b1; we = i_we; size = i_size; uns = i_uns; addr = i_addr; wdata = i_wd;
        bus_q.push_back('{{i_addr[31:2], 2'b00}, i_we, exp_wd, exp_sel, exp_dmem});
        resp_q.push_back('{exp_rd, exp_err, i_we, i_addr});
        #1 check("stall_accept", 32'(stall), 32'd1);
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("req_cycle1", 32'(dreq), 32'd1);
            if (cyc == 2) check("req_cycle2", 32'(dreq), 32'd0);
            if (wvalid) begin
                done = 1'b1;
                req  = 1'b0;
                check("latency", cyc, exp_lat);
                check("stall_resp", 32'(stall), 32'd0);
            end else begin
                check("stall_busy", 32'(stall), 32'd1);
            end
        end
        req = 1'b0;
        if (!done) check("valid_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic run_mis(input logic i_we, input logic [1:0] i_size, input logic [31:0] i_addr);
        @(negedge clk);
        req = 1'b1; we = i_we; size = i_size; uns = 1'b0; addr = i_addr; wdata = 32'h0;
        mis_q.push_back('{i_addr, i_we});
        #1 check("mis_stall", 32'(stall), 32'd0);
        @(negedge clk);
        req = 1'b0;
        check("mis_pulse", 32'(misalign), 32'd1);
        check("mis_no_req", 32'(dreq), 32'd0);
        @(negedge clk);
        check("mis_one_cycle", 32'(misalign), 32'd0);
        check("mis_no_req2", 32'(dreq), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {22'd0, stall, dreq, dwe, dmem_sel, peri_sel, wvalid, misalign, is_store, bus_err, 1'b0}, 32'd0);
        check("rst_bus", daddr | dwdata | {28'd0, dsel}, 32'd0);
        check("rst_out", wrdata | badaddr, 32'd0);
        rst_n = 1'b1;

        run_op(1, 2'b10, 0, 32'h8000_0004, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 3, 32'h0, 0, 4'hF, 32'hDEAD_BEEF, 1);
        run_op(1, 2'b00, 0, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0, 3, 32'h0, 0, 4'h8, 32'hA5A5_A5A5, 1);
        run_op(0, 2'b00, 0, 32'h8000_0002, 32'h0, 32'h0080_0000, 0, 3, 32'hFFFF_FF80, 0, 4'h4, 32'h0, 1);
        run_op(0, 2'b00, 1, 32'h8000_0002, 32'h0, 32'h0080_0000, 0, 3, 32'h0000_0080, 0, 4'h4, 32'h0, 1);
        run_op(0, 2'b01, 0, 32'h8000_0002, 32'h0, 32'h8001_0000, 0, 3, 32'hFFFF_8001, 0, 4'hC, 32'h0, 1);
        run_op(1, 2'b01, 0, 32'h4000_0002, 32'h0000_1234, 32'h0, 2, 5, 32'h0, 0, 4'hC, 32'h1234_1234, 0);
        run_op(0, 2'b01, 1, 32'h8000_0000, 32'h0, 32'h0000_F00D, 0, 3, 32'h0000_F00D, 0, 4'h3, 32'h0, 1);
        run_op(0, 2'b00, 0, 32'h8000_0001, 32'h0, 32'h0000_7F00, 1, 4, 32'h0000_007F, 0, 4'h2, 32'h0, 1);
        run_op(0, 2'b11, 0, 32'h8000_000C, 32'h0, 32'hCAFE_F00D, 0, 3, 32'hCAFE_F00D, 0, 4'hF, 32'h0, 1);

        run_mis(0, 2'b10, 32'h8000_0006);
        run_mis(1, 2'b01, 32'h8000_0001);

`ifdef LSU_BUS_TIMEOUT_EN
        run_op(0, 2'b10, 0, 32'h4000_0000, 32'h0, 32'h1122_3344, 300, 257, 32'h0, 1, 4'hF, 32'h0, 0);
`else
        run_op(0, 2'b10, 0, 32'h4000_0000, 32'h0, 32'h1122_3344, 300, 303, 32'h1122_3344, 0, 4'hF, 32'h0, 0);
`endif

        wait_slave();
        slave_rdata = 32'h0BAD_0BAD;
        ack_wait    = 20;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h8000_0010; wdata = 32'h0;
        bus_q.push_back('{32'h8000_0010, 1'b0, 32'h0, 4'hF, 1'b1});
        repeat (4) @(negedge clk);
        check("stall_in_wait", 32'(stall), 32'd1);
        rst_n = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_wait_stall", 32'(stall), 32'd0);
        check("rst_wait_outs", {29'd0, dreq, wvalid, misalign}, 32'd0);
        wait_slave();
        run_op(0, 2'b10, 0, 32'h8000_0010, 32'h0, 32'h5A5A_A5A5, 0, 3, 32'h5A5A_A5A5, 0, 4'hF, 32'h0, 1);

        repeat (3) @(negedge clk);
        check("queues_empty", bus_q.size() + resp_q.size() + mis_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and the data bus. Converts execute-stage load/store requests (byte/half/word, signed/unsigned) into single-cycle data-bus requests with byte-lane select and lane-replicated write data, decodes data-memory vs peripheral target, waits for the bus acknowledge, and returns sign/zero-extended load data to writeback. Stalls the pipeline for the transaction and flags misaligned accesses to the CSR/trap logic without issuing a bus access.

## Interface
- `DMEM_REGION`, 4'h8: value of addr[31:28] that selects data memory; any other value selects the peripheral bus.
- `TIMEOUT_CYCLES`, 255: WAIT-state cycles before bus error (only with `LSU_BUS_TIMEOUT_EN`); max 255.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `exe2lsu_req_i` in 1: load/store request, held by execute while stalled.
- `exe2lsu_we_i` in 1: 1 = store, 0 = load.
- `exe2lsu_size_i` in 2: 00 byte, 01 half, 10 word; 11 treated as word.
- `exe2lsu_unsigned_i` in 1: zero-extend load (LBU/LHU).
- `exe2lsu_addr_i` in 32: byte address.
- `exe2lsu_wdata_i` in 32: store data, right-aligned.
- `lsu2exe_stall_o` out 1: pipeline stall.
- `lsu2dbus_req_o` / `_we_o` out 1 each; `lsu2dbus_addr_o` out 32; `lsu2dbus_wdata_o` out 32; `lsu2dbus_sel_byte_o` out 4.
- `lsu2dbus_dmem_sel_o`, `lsu2dbus_peri_sel_o` out 1 each: target decode, one-hot while req high.
- `dbus2lsu_rdata_i` in 32; `dbus2lsu_ack_i` in 1.
- `lsu2wrb_valid_o` out 1; `lsu2wrb_rdata_o` out 32: formatted load data.
- `lsu2csr_misalign_o` out 1; `lsu2csr_is_store_o` out 1; `lsu2csr_badaddr_o` out 32; `lsu2csr_bus_err_o` out 1.

## Operation
- FSM: IDLE, REQ, WAIT, RESP. Reset → IDLE; all outputs 0.
- IDLE: req_i and aligned → latch we/size/unsigned/addr/lane data, → REQ. Misaligned (half with addr[0]=1, word with addr[1:0]≠0) → no bus access, next cycle misalign_o=1 for one cycle with badaddr_o=addr, is_store_o=we; remain IDLE.
- REQ: dbus req_o=1 exactly one cycle with latched fields → WAIT.
- WAIT: req_o=0; ack_i=1 → capture rdata → RESP.
- RESP: wrb_valid_o=1 one cycle (loads and stores), rdata_o formatted (0 for stores) → IDLE.
- New requests accepted only in IDLE; req_i during RESP is the completing instruction and is ignored.
- ack_i in IDLE or REQ ignored.
- sel_byte: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
- wdata: byte replicated ×4, half replicated ×2, word unchanged.
- Load format: byte lane addr[1:0], half lane addr[1]; sign-extend unless unsigned_i; word passes through.
- bus addr_o = latched addr with [1:0] forced to 00.

## Timing
- Stall: combinational 1 in IDLE when req_i and aligned; 1 in REQ and WAIT; 0 in RESP and IDLE otherwise.
- Against a 1-cycle-ack slave, req_i accepted cycle 0: req_o cycle 1, ack cycle 2, valid_o cycle 3; stall high cycles 0–2.
- Misaligned: zero stall cycles; misalign_o one cycle later.
- rst_n low in any state: next edge IDLE, outputs 0, in-flight transaction dropped.

## Configuration
- `LSU_BUS_TIMEOUT_EN` defined: 8-bit counter clears on entering WAIT, increments per WAIT cycle; reaching TIMEOUT_CYCLES without ack → RESP with bus_err_o=1 (one cycle, with valid_o), rdata_o=0, badaddr_o=addr.
- Undefined: WAIT indefinitely; bus_err_o tied 0; no counter.

## Structure
- Shared interface-defs package: size encodings (SIZE_BYTE/HALF/WORD), FSM state enum, DMEM_REGION default.
- Sub-module `lsu_data_align`: combinational store lane/sel_byte generation and load extraction/extension.

## Test plan
- SW 0x8000_0004 data 0xDEADBEEF → req_o cycle 1, sel 1111, addr 0x8000_0004, dmem_sel=1; valid_o cycle 3.
- SB addr 0x8000_0003 data 0x000000A5 → sel 1000, wdata 0xA5A5A5A5.
- LB addr 0x8000_0002, rdata 0x0080_0000 → rdata_o 0xFFFF_FF80; LBU → 0x0000_0080; LH addr 0x8000_0002, rdata 0x8001_0000 → 0xFFFF_8001.
- LW addr 0x8000_0006 → no req_o, stall low, misalign_o=1, badaddr 0x8000_0006, is_store=0.
- Load to 0x4000_0000, ack withheld 300 cycles: with macro, bus_err_o + valid_o after 255 WAIT cycles; without, stall held until ack.
- rst_n low during WAIT → IDLE next edge, stall 0; subsequent LW completes normally.
